// File: rtl/rapcla_qc_pkg.sv
// Shared types and helpers for the approximate-CLA quality controller.
// Width helpers are functions so every user derives them from its own parameters.
package rapcla_qc_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_DECIDE  = 2'd2,
      S_SETTLE  = 2'd3
   } qc_state_e;

   function automatic int ngrp_f(input int size, input int grpsize);
      return size / grpsize;
   endfunction

   function automatic int err_cnt_w_f(input int win_len);
      return $clog2(win_len + 1);
   endfunction

   function automatic int max_ed_w_f(input int size);
      return size + 1;
   endfunction

   function automatic int med_sum_w_f(input int size, input int win_len);
      return size + 1 + $clog2(win_len);
   endfunction

   // Thermometer masks grow from the LSB group; saturation falls out of the masking.
   function automatic logic [31:0] therm_up_f(input logic [31:0] rcon, input int ngrp);
      logic [31:0] mask_v;
      mask_v = (ngrp >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ngrp) - 32'd1);
      return ((rcon << 1) | 32'd1) & mask_v;
   endfunction

   function automatic logic [31:0] therm_down_f(input logic [31:0] rcon);
      return rcon >> 1;
   endfunction

endpackage

// File: rtl/rapcla_err_dist.sv
// Recomputes the exact sum of one operand pair and returns the absolute
// distance to the approximate adder result.
module rapcla_err_dist #(
   parameter int SIZE = 16
) (
   input  logic [SIZE-1:0] a_i,
   input  logic [SIZE-1:0] b_i,
   input  logic            cin_i,
   input  logic [SIZE-1:0] apx_sum_i,
   input  logic            apx_cout_i,
   output logic [SIZE:0]   ed_o,
   output logic            err_o
);

   logic [SIZE:0] exact_s;
   logic [SIZE:0] approx_s;

   assign exact_s  = {1'b0, a_i} + {1'b0, b_i} + {{SIZE{1'b0}}, cin_i};
   assign approx_s = {apx_cout_i, apx_sum_i};

   // Unsigned absolute difference, subtracting the smaller from the larger.
   always_comb begin
      if (exact_s >= approx_s) begin
         ed_o = exact_s - approx_s;
      end else begin
         ed_o = approx_s - exact_s;
      end
   end

   assign err_o = (ed_o != '0);

endmodule

// File: rtl/rapcla_quality_ctrl.sv
// Windowed error monitor that steps the adder's ApproxRCON thermometer mask.
// Define RAPCLA_QC_MED_SUM_EN to keep the summed-error-distance accumulator on MED_SUM.
module rapcla_quality_ctrl
   import rapcla_qc_pkg::*;
#(
   parameter int SIZE      = 16,
   parameter int GROUPSIZE = 8,
   parameter int WIN_LEN   = 16,
   parameter int ERR_HI    = 4,
   parameter int ERR_LO    = 1,
   parameter int SETTLE    = 2
) (
   input  logic                                       CLK,
   input  logic                                       RST_N,
   input  logic                                       EN,
   input  logic                                       IN_VALID,
   output logic                                       IN_READY,
   input  logic [SIZE-1:0]                            A,
   input  logic [SIZE-1:0]                            B,
   input  logic                                       CIN,
   input  logic [SIZE-1:0]                            APX_SUM,
   input  logic                                       APX_COUT,
   output logic [ngrp_f(SIZE, GROUPSIZE)-1:0]         APPROX_RCON,
   output logic [err_cnt_w_f(WIN_LEN)-1:0]            ERR_CNT,
   output logic [max_ed_w_f(SIZE)-1:0]                MAX_ED,
   output logic                                       WIN_DONE,
   output logic [med_sum_w_f(SIZE, WIN_LEN)-1:0]      MED_SUM
);

   localparam int NGRP  = ngrp_f(SIZE, GROUPSIZE);
   localparam int ERR_W = err_cnt_w_f(WIN_LEN);
   localparam int ED_W  = max_ed_w_f(SIZE);
   localparam int SUM_W = med_sum_w_f(SIZE, WIN_LEN);
   localparam int SET_W = $clog2(SETTLE + 1);

   logic [ED_W-1:0]  ed_s;
   logic             err_s;

   qc_state_e        state_q;
   logic             ready_q;
   logic             win_done_q;
   logic [NGRP-1:0]  rcon_q;
   logic [NGRP-1:0]  rcon_d;
   logic [ERR_W-1:0] err_cnt_q;
   logic [ED_W-1:0]  max_ed_q;
   logic [ERR_W-1:0] smp_cnt_q;
   logic [ERR_W-1:0] err_acc_q;
   logic [ERR_W-1:0] err_acc_d;
   logic [ED_W-1:0]  max_acc_q;
   logic [ED_W-1:0]  max_acc_d;
   logic [SET_W-1:0] set_cnt_q;

   logic             accept_s;
   logic             last_s;
   logic             clr_s;

   rapcla_err_dist #(
      .SIZE (SIZE)
   ) u_err_dist (
      .a_i        (A),
      .b_i        (B),
      .cin_i      (CIN),
      .apx_sum_i  (APX_SUM),
      .apx_cout_i (APX_COUT),
      .ed_o       (ed_s),
      .err_o      (err_s)
   );

   // A sample taken while EN is low would be discarded with the window anyway.
   assign accept_s  = (state_q == S_MEASURE) && ready_q && IN_VALID && EN;
   assign last_s    = accept_s && (smp_cnt_q == ERR_W'(WIN_LEN - 1));
   assign clr_s     = ((state_q == S_IDLE) && EN) || ((state_q == S_MEASURE) && !EN);
   assign err_acc_d = err_acc_q + ERR_W'(err_s);
   assign max_acc_d = (ed_s > max_acc_q) ? ed_s : max_acc_q;

   // Mask step chosen from the error count including the window's final sample.
   always_comb begin
      if (err_acc_d > ERR_W'(ERR_HI)) begin
         rcon_d = NGRP'(therm_down_f(32'(rcon_q)));
      end else if (err_acc_d < ERR_W'(ERR_LO)) begin
         rcon_d = NGRP'(therm_up_f(32'(rcon_q), NGRP));
      end else begin
         rcon_d = rcon_q;
      end
   end

   // Window FSM; results publish on the last accepted sample so DECIDE shows them.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b0;
         win_done_q <= 1'b0;
         rcon_q     <= '0;
         err_cnt_q  <= '0;
         max_ed_q   <= '0;
         smp_cnt_q  <= '0;
         err_acc_q  <= '0;
         max_acc_q  <= '0;
         set_cnt_q  <= '0;
      end else begin
         win_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b0;
               if (EN) begin
                  state_q   <= S_MEASURE;
                  ready_q   <= 1'b1;
                  smp_cnt_q <= '0;
                  err_acc_q <= '0;
                  max_acc_q <= '0;
               end
            end
            S_MEASURE: begin
               if (!EN) begin
                  state_q   <= S_IDLE;
                  ready_q   <= 1'b0;
                  smp_cnt_q <= '0;
                  err_acc_q <= '0;
                  max_acc_q <= '0;
               end else if (last_s) begin
                  state_q    <= S_DECIDE;
                  ready_q    <= 1'b0;
                  win_done_q <= 1'b1;
                  err_cnt_q  <= err_acc_d;
                  max_ed_q   <= max_acc_d;
                  rcon_q     <= rcon_d;
                  smp_cnt_q  <= '0;
                  err_acc_q  <= '0;
                  max_acc_q  <= '0;
               end else if (accept_s) begin
                  smp_cnt_q <= smp_cnt_q + ERR_W'(1);
                  err_acc_q <= err_acc_d;
                  max_acc_q <= max_acc_d;
               end
            end
            S_DECIDE: begin
               state_q   <= S_SETTLE;
               ready_q   <= 1'b0;
               set_cnt_q <= SET_W'(SETTLE - 1);
            end
            S_SETTLE: begin
               if (set_cnt_q == '0) begin
                  state_q <= EN ? S_MEASURE : S_IDLE;
                  ready_q <= EN;
               end else begin
                  set_cnt_q <= set_cnt_q - SET_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef RAPCLA_QC_MED_SUM_EN
   logic [SUM_W-1:0] sum_acc_q;
   logic [SUM_W-1:0] sum_acc_d;
   logic [SUM_W-1:0] med_sum_q;

   assign sum_acc_d = sum_acc_q + SUM_W'(ed_s);

   // Summed error distance follows the same clear/accept/publish strobes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sum_acc_q <= '0;
         med_sum_q <= '0;
      end else if (last_s) begin
         med_sum_q <= sum_acc_d;
         sum_acc_q <= '0;
      end else if (clr_s) begin
         sum_acc_q <= '0;
      end else if (accept_s) begin
         sum_acc_q <= sum_acc_d;
      end
   end

   assign MED_SUM = med_sum_q;
`else
   assign MED_SUM = '0;
`endif

   assign IN_READY    = ready_q;
   assign WIN_DONE    = win_done_q;
   assign APPROX_RCON = rcon_q;
   assign ERR_CNT     = err_cnt_q;
   assign MAX_ED      = max_ed_q;

endmodule
